dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store port and a DMA/loader port (program preload, debug).
- Sits between the core's memory-stage signals (address = ALU result, write data = rs2, 2-bit store code) and the data memory.
- Returns a stall to the core while its access is pending.
- Fixed core priority, with a starvation limit that guarantees DMA progress.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles (≥1) from the address-drive cycle to valid m_rdata.
- MAX_WAIT, 4, number of consecutive lost arbitrations after which DMA wins the next one (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  core access request; held until c_done.
- c_rwe  in  2  core store code; 00 = load, non-zero = store, passed unchanged to the memory.
- c_addr  in  AW  core byte address.
- c_wdata  in  DW  core store data.
- c_rdata  out  DW  core load data, registered.
- c_done  out  1  one-cycle completion pulse for the core.
- c_stall  out  1  combinational: c_req & ~c_done; core holds pc and the instruction while high.
- d_req, d_rwe, d_addr, d_wdata  in  1/2/AW/DW  DMA equivalents of the core inputs.
- d_rdata  out  DW  DMA load data, registered.
- d_done  out  1  one-cycle completion pulse for DMA.
- d_gnt  out  1  high while a DMA transaction is in ACCESS or WAIT.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rwe  out  2  memory write enable / store code.
- m_rdata  in  DW  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - State = IDLE.
  - m_addr, m_wdata, c_rdata, d_rdata = 0.
  - m_rwe = 0; also forced 0 combinationally while rst = 1, so no write occurs in a reset cycle.
  - c_done, d_done, d_gnt, busy = 0.
  - Starvation counter = 0; owner = core.
- States:
  - IDLE: no transaction in progress.
  - ACCESS: one cycle, memory driven.
  - WAIT: loads only; RD_LAT cycles.
  - DONE: one cycle, completion pulse.
- IDLE:
  - If any req is high, pick the winner and latch its rwe/addr/wdata into the m_* registers and the owner register; go to ACCESS.
  - With no req, stay in IDLE with m_rwe = 0.
- Arbitration (evaluated only in IDLE):
  - Only one requester high → it wins.
  - Both high → core wins unless counter == MAX_WAIT, in which case DMA wins.
  - Counter update:
    - Increments (saturating at MAX_WAIT) when DMA requests and loses.
    - Clears when DMA is granted.
    - Otherwise unchanged.
- ACCESS (1 cycle):
  - m_addr/m_wdata hold the latched values.
  - m_rwe = latched code for a store, 00 for a load.
  - Store → DONE. Load → WAIT with the latency counter = RD_LAT-1.
- WAIT:
  - Decrement each cycle.
  - When the counter reaches 0, capture m_rdata into the owner's rdata register and go to DONE.
  - Total capture point: RD_LAT cycles after the ACCESS cycle.
  - m_addr is held stable; m_rwe = 0.
- DONE (1 cycle):
  - Owner's done = 1; m_rwe = 0.
  - Next state is IDLE; the next grant occurs in the following IDLE cycle.
- Cost per access:
  - Store occupies 3 cycles (IDLE grant, ACCESS, DONE).
  - Load occupies 3 + RD_LAT cycles.
- Payload sampling:
  - Payload is sampled only at grant; changes to addr/wdata/rwe after grant are ignored.
  - A requester dropping req mid-transaction does not abort it; done still pulses.
- rdata registers hold their value until the owner's next load completes. Stores do not alter rdata.
- The non-owner's done and rdata are never disturbed by the owner's transaction.
- Reset asserted in any state returns to IDLE next edge:
  - No done pulse.
  - An in-flight load result is discarded.
  - An in-flight store in an ACCESS cycle coinciding with rst is suppressed by the forced m_rwe = 0.

Test Plan:
- Core load alone: mem[0x40] = 0xDEADBEEF, c_req = 1, c_rwe = 00, c_addr = 0x40, RD_LAT = 1 → m_addr = 0x40 in cycle 2, c_rdata = 0xDEADBEEF with c_done = 1 in cycle 4, c_stall = 1 in cycles 1–3, d_gnt = 0 throughout.
- Core store: c_rwe = 11, c_addr = 0x10, c_wdata = 0x12345678 → m_rwe = 11 for exactly one cycle, c_done in cycle 3, readback of 0x10 returns 0x12345678.
- Starvation: c_req and d_req held high continuously, MAX_WAIT = 4 → grant order C, C, C, C, D, C, C, C, C, D; counter clears after each D.
- Simultaneous first request: both rise in the same cycle with counter = 0 → core granted, d_gnt = 0 until core's DONE, DMA granted in the next IDLE cycle.
- Reset mid-load: assert rst during WAIT (RD_LAT = 3) → next cycle busy = 0, no c_done, c_rdata = 0, m_rwe = 0. A store with rst in its ACCESS cycle leaves memory unchanged.
- Payload change after grant: c_addr switches 0x40 → 0x80 in the ACCESS cycle → m_addr stays 0x40, returned data from 0x40.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (core, DMA)
// and the single-port data memory.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic [1:0]    c_rwe;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_done;
  logic          c_stall;

  logic          d_req;
  logic [1:0]    d_rwe;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          d_gnt;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [1:0]    m_rwe;
  logic [DW-1:0] m_rdata;

  logic          busy;

  modport slave (
    input  c_req, c_rwe, c_addr, c_wdata,
    output c_rdata, c_done, c_stall,
    input  d_req, d_rwe, d_addr, d_wdata,
    output d_rdata, d_done, d_gnt,
    output m_addr, m_wdata, m_rwe,
    input  m_rdata,
    output busy
  );

  modport master (
    output c_req, c_rwe, c_addr, c_wdata,
    input  c_rdata, c_done, c_stall,
    output d_req, d_rwe, d_addr, d_wdata,
    input  d_rdata, d_done, d_gnt,
    input  m_addr, m_wdata, m_rwe,
    output m_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: fixed core priority,
// with a starvation counter that hands DMA the grant after MAX_WAIT losses.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          own_dma_q, own_dma_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    rwe_q, rwe_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          dma_wins;

  assign dma_wins = bus.d_req & (~bus.c_req | (cnt_q == CW'(MAX_WAIT)));

  always_comb begin
    state_d   = state_q;
    own_dma_d = own_dma_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rwe_d     = rwe_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.c_req | bus.d_req) begin
          own_dma_d = dma_wins;
          addr_d    = dma_wins ? bus.d_addr  : bus.c_addr;
          wdata_d   = dma_wins ? bus.d_wdata : bus.c_wdata;
          rwe_d     = dma_wins ? bus.d_rwe   : bus.c_rwe;
          state_d   = S_ACCESS;
          // DMA only "loses" when the core also asked and took the slot
          if (dma_wins)
            cnt_d = '0;
          else if (bus.d_req && cnt_q != CW'(MAX_WAIT))
            cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACCESS: begin
        if (rwe_q != 2'b00) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          lat_d   = LW'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          if (own_dma_q) d_rdata_d = bus.m_rdata;
          else           c_rdata_d = bus.m_rdata;
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      own_dma_q <= 1'b0;
      cnt_q     <= '0;
      lat_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rwe_q     <= 2'b00;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      own_dma_q <= own_dma_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rwe_q     <= rwe_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Write strobe gated by rst so a store caught by reset never reaches memory
  assign bus.m_rwe   = (state_q == S_ACCESS && !rst) ? rwe_q : 2'b00;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.c_done  = (state_q == S_DONE) & ~own_dma_q;
  assign bus.d_done  = (state_q == S_DONE) &  own_dma_q;
  assign bus.c_stall = bus.c_req & ~bus.c_done;
  assign bus.d_gnt   = own_dma_q & ((state_q == S_ACCESS) | (state_q == S_WAIT));
  assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: instance A (RD_LAT=1) runs a cycle table plus a starvation
// sequence; instance B (RD_LAT=3) covers latency and reset-abort cases.
module tb_dmem_arbiter;

  logic clk;
  logic rst_a, rst_b, pre;
  int   total, bad;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus_a ();
  dmem_arbiter_if #(.AW(32), .DW(32)) bus_b ();

  dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );
  dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: word array plus an RD_LAT-deep read pipeline
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 32'h0;
      mem_a[16] <= 32'hDEADBEEF;
      mem_a[32] <= 32'h0BADF00D;
    end else if (bus_a.m_rwe != 2'b00) begin
      mem_a[bus_a.m_addr[9:2]] <= bus_a.m_wdata;
    end
    pipe_a <= mem_a[bus_a.m_addr[9:2]];
  end
  assign bus_a.m_rdata = pipe_a;

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 32'h0;
      mem_b[16] <= 32'hCAFEF00D;
      mem_b[8]  <= 32'h11111111;
    end else if (bus_b.m_rwe != 2'b00) begin
      mem_b[bus_b.m_addr[9:2]] <= bus_b.m_wdata;
    end
    pipe_b[0] <= mem_b[bus_b.m_addr[9:2]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_b.m_rdata = pipe_b[2];

  typedef struct {
    logic        c_req;
    logic [1:0]  c_rwe;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] e_maddr;
    logic [1:0]  e_mrwe;
    logic [4:0]  e_flags;  // {busy, c_done, c_stall, d_done, d_gnt}
    logic [31:0] e_crd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t v(input logic cr, input logic [1:0] crwe,
                             input logic [31:0] ca, input logic [31:0] cw,
                             input logic dr, input logic [31:0] da,
                             input logic [31:0] ema, input logic [1:0] emr,
                             input logic [4:0] ef, input logic [31:0] ecr,
                             input logic [31:0] edr);
    vec_t r;
    r.c_req = cr; r.c_rwe = crwe; r.c_addr = ca; r.c_wdata = cw;
    r.d_req = dr; r.d_addr = da;
    r.e_maddr = ema; r.e_mrwe = emr; r.e_flags = ef;
    r.e_crd = ecr; r.e_drd = edr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] snap_a();
    return {25'd0, bus_a.m_addr, bus_a.m_rwe, bus_a.busy, bus_a.c_done,
            bus_a.c_stall, bus_a.d_done, bus_a.d_gnt, bus_a.c_rdata,
            bus_a.d_rdata};
  endfunction

  initial begin
    logic [9:0]  exp_order;
    logic [5:0]  done_hist;
    logic [2:0]  late_done;
    logic [1:0]  got;
    logic        found;

    total = 0; bad = 0;
    rst_a = 1'b1; rst_b = 1'b1; pre = 1'b1;
    bus_a.c_req = 0; bus_a.c_rwe = 0; bus_a.c_addr = 0; bus_a.c_wdata = 0;
    bus_a.d_req = 0; bus_a.d_rwe = 0; bus_a.d_addr = 0; bus_a.d_wdata = 0;
    bus_b.c_req = 0; bus_b.c_rwe = 0; bus_b.c_addr = 0; bus_b.c_wdata = 0;
    bus_b.d_req = 0; bus_b.d_rwe = 0; bus_b.d_addr = 0; bus_b.d_wdata = 0;

    //           cr crwe c_addr  c_wdata       dr d_addr  m_addr  mrwe flags     c_rdata       d_rdata
    tbl[0]  = v(1, 0, 32'h40, 32'h0,        0, 32'h0,  32'h0,  0, 5'b00100, 32'h0,        32'h0);
    tbl[1]  = v(1, 0, 32'h40, 32'h0,        0, 32'h0,  32'h40, 0, 5'b10100, 32'h0,        32'h0);
    tbl[2]  = v(1, 0, 32'h40, 32'h0,        0, 32'h0,  32'h40, 0, 5'b10100, 32'h0,        32'h0);
    tbl[3]  = v(1, 0, 32'h40, 32'h0,        0, 32'h0,  32'h40, 0, 5'b11000, 32'hDEADBEEF, 32'h0);
    tbl[4]  = v(1, 3, 32'h10, 32'h12345678, 0, 32'h0,  32'h40, 0, 5'b00100, 32'hDEADBEEF, 32'h0);
    tbl[5]  = v(1, 3, 32'h10, 32'h12345678, 0, 32'h0,  32'h10, 3, 5'b10100, 32'hDEADBEEF, 32'h0);
    tbl[6]  = v(1, 3, 32'h10, 32'h12345678, 0, 32'h0,  32'h10, 0, 5'b11000, 32'hDEADBEEF, 32'h0);
    tbl[7]  = v(1, 0, 32'h10, 32'h0,        0, 32'h0,  32'h10, 0, 5'b00100, 32'hDEADBEEF, 32'h0);
    tbl[8]  = v(1, 0, 32'h80, 32'h0,        0, 32'h0,  32'h10, 0, 5'b10100, 32'hDEADBEEF, 32'h0);
    tbl[9]  = v(1, 0, 32'h80, 32'h0,        0, 32'h0,  32'h10, 0, 5'b10100, 32'hDEADBEEF, 32'h0);
    tbl[10] = v(1, 0, 32'h80, 32'h0,        0, 32'h0,  32'h10, 0, 5'b11000, 32'h12345678, 32'h0);
    tbl[11] = v(0, 0, 32'h0,  32'h0,        0, 32'h0,  32'h10, 0, 5'b00000, 32'h12345678, 32'h0);
    tbl[12] = v(1, 0, 32'h40, 32'h0,        1, 32'h80, 32'h10, 0, 5'b00100, 32'h12345678, 32'h0);
    tbl[13] = v(1, 0, 32'h40, 32'h0,        1, 32'h80, 32'h40, 0, 5'b10100, 32'h12345678, 32'h0);
    tbl[14] = v(1, 0, 32'h40, 32'h0,        1, 32'h80, 32'h40, 0, 5'b10100, 32'h12345678, 32'h0);
    tbl[15] = v(1, 0, 32'h40, 32'h0,        1, 32'h80, 32'h40, 0, 5'b11000, 32'hDEADBEEF, 32'h0);
    tbl[16] = v(0, 0, 32'h0,  32'h0,        1, 32'h80, 32'h40, 0, 5'b00000, 32'hDEADBEEF, 32'h0);
    tbl[17] = v(0, 0, 32'h0,  32'h0,        1, 32'h80, 32'h80, 0, 5'b10001, 32'hDEADBEEF, 32'h0);
    tbl[18] = v(0, 0, 32'h0,  32'h0,        1, 32'h80, 32'h80, 0, 5'b10001, 32'hDEADBEEF, 32'h0);
    tbl[19] = v(0, 0, 32'h0,  32'h0,        1, 32'h80, 32'h80, 0, 5'b10010, 32'hDEADBEEF, 32'h0BADF00D);
    tbl[20] = v(0, 0, 32'h0,  32'h0,        0, 32'h0,  32'h80, 0, 5'b00000, 32'hDEADBEEF, 32'h0BADF00D);

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0; pre = 1'b0;
    @(negedge clk);
    chk("reset_a", snap_a(), 128'd0);

    for (int i = 0; i < 21; i++) begin
      next_cycle();
      bus_a.c_req  = tbl[i].c_req;
      bus_a.c_rwe  = tbl[i].c_rwe;
      bus_a.c_addr = tbl[i].c_addr;
      bus_a.c_wdata = tbl[i].c_wdata;
      bus_a.d_req  = tbl[i].d_req;
      bus_a.d_addr = tbl[i].d_addr;
      @(negedge clk);
      chk($sformatf("row%0d", i + 1), snap_a(),
          {25'd0, tbl[i].e_maddr, tbl[i].e_mrwe, tbl[i].e_flags,
           tbl[i].e_crd, tbl[i].e_drd});
    end

    // Starvation: both requesters held high; expected order C C C C D C C C C D
    exp_order = 10'b10_0001_0000;
    next_cycle();
    bus_a.c_req = 1; bus_a.c_rwe = 0; bus_a.c_addr = 32'h40;
    bus_a.d_req = 1; bus_a.d_rwe = 0; bus_a.d_addr = 32'h80;
    for (int n = 0; n < 10; n++) begin
      found = 1'b0;
      got   = 2'd2;
      for (int w = 0; w < 30 && !found; w++) begin
        @(negedge clk);
        if (bus_a.c_done || bus_a.d_done) begin
          found = 1'b1;
          got   = {1'b0, bus_a.d_done};
        end
      end
      chk($sformatf("grant%0d", n), {126'd0, got}, {126'd0, 1'b0, exp_order[n]});
    end
    next_cycle();
    bus_a.c_req = 0; bus_a.d_req = 0;
    @(negedge clk);
    chk("starve_idle", {127'd0, bus_a.busy}, 128'd0);

    // Instance B: plain load with RD_LAT=3, done expected in cycle 6
    next_cycle();
    bus_b.c_req = 1; bus_b.c_rwe = 0; bus_b.c_addr = 32'h40;
    done_hist = '0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      done_hist[k] = bus_b.c_done;
    end
    chk("b_load_latency", {122'd0, done_hist}, {122'd0, 6'b100000});
    chk("b_load_data", {96'd0, bus_b.c_rdata}, {96'd0, 32'hCAFEF00D});
    next_cycle();
    bus_b.c_req = 0;

    // Reset during WAIT: cycles 1 grant, 2 access, 3-4 wait, rst in 4
    next_cycle();
    bus_b.c_req = 1;
    next_cycle();
    next_cycle();
    next_cycle();
    rst_b = 1'b1;
    next_cycle();
    rst_b = 1'b0; bus_b.c_req = 0;
    @(negedge clk);
    chk("b_rst_load", {25'd0, bus_b.busy, bus_b.c_done, bus_b.m_rwe, bus_b.c_rdata},
        128'd0);
    late_done = '0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      late_done[k] = bus_b.c_done;
    end
    chk("b_no_late_done", {125'd0, late_done}, 128'd0);

    // Store whose ACCESS cycle coincides with reset must not write
    next_cycle();
    bus_b.c_req = 1; bus_b.c_rwe = 2'b11; bus_b.c_addr = 32'h20;
    bus_b.c_wdata = 32'h55AA55AA;
    next_cycle();
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_rst_store_mrwe", {126'd0, bus_b.m_rwe}, 128'd0);
    next_cycle();
    rst_b = 1'b0; bus_b.c_req = 0;
    @(negedge clk);
    chk("b_rst_store_mem", {96'd0, mem_b[8]}, {96'd0, 32'h11111111});
    chk("b_rst_store_idle", {126'd0, bus_b.busy, bus_b.c_done}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
